// File: rtl/gcd_core.sv
// Iterative subtract-and-swap Euclid GCD engine. It latches both operands on start,
// iterates to gcd(a,b), then pulses done with the result and the subtraction count.
module gcd_core #(
    parameter int WIDTH = 12
) (
    input  logic             lcdclk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH:0]   iter_cnt,
    output logic             zero_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   iter_q, iter_d;
    logic             zerr_q, zerr_d;

    logic a_zero, b_zero;
    assign a_zero = (a_q == '0);
    assign b_zero = (b_q == '0);

    always_ff @(posedge lcdclk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            iter_q   <= '0;
            zerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            iter_q   <= iter_d;
            zerr_q   <= zerr_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        iter_d   = iter_q;
        zerr_d   = zerr_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy    = 1'b1;
                state_d = CALC;
                // One rule per cycle; subtraction always larger-minus-smaller, so no borrow.
                if (a_zero || b_zero) begin
                    result_d = a_q | b_q;
                    zerr_d   = a_zero && b_zero;
                    iter_d   = cnt_q;
                    state_d  = DONE;
                end else if (a_q == b_q) begin
                    result_d = a_q;
                    zerr_d   = 1'b0;
                    iter_d   = cnt_q;
                    state_d  = DONE;
                end else if (a_q > b_q) begin
                    a_d   = a_q - b_q;
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    b_d   = b_q - a_q;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result   = result_q;
    assign iter_cnt = iter_q;
    assign zero_err = zerr_q;

endmodule

// File: tb/tb_gcd_core.sv
// Scoreboard bench for gcd_core: expectations are queued at start and retired on done.
module tb_gcd_core;

    localparam int WIDTH = 12;

    logic             lcdclk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   iter_cnt;
    logic             zero_err;

    gcd_core #(.WIDTH(WIDTH)) dut (
        .lcdclk  (lcdclk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .iter_cnt(iter_cnt),
        .zero_err(zero_err)
    );

    always #5 lcdclk = ~lcdclk;

    typedef struct {
        int r;
        int n;
        bit z;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result from modulo Euclid; count from the subtract-only definition.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   x = a, y = b, t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        e.r = x;
        e.z = (a == 0 && b == 0);
        e.n = 0;
        x = a; y = b;
        while (x != 0 && y != 0 && x != y) begin
            if (x > y) x = x - y; else y = y - x;
            e.n++;
        end
        return e;
    endfunction

    // Retire scoreboard entries whenever the DUT reports completion.
    always @(negedge lcdclk) begin
        if (done === 1'b1) begin
            exp_t e;
            chk("busy_at_done", busy, 0);
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("iter_cnt", iter_cnt, e.n);
                chk("zero_err", zero_err, e.z);
            end
        end
    end

    // ghost: also pulse start in cycle 2 and in the DONE cycle; both must be ignored.
    task automatic run_op(input int a, input int b, input bit ghost);
        exp_t e;
        int   k;
        bit   seen;
        e = model(a, b);
        @(negedge lcdclk);
        start = 1'b1;
        a_in  = WIDTH'(a);
        b_in  = WIDTH'(b);
        sb.push_back(e);
        k = 0;
        seen = 1'b0;
        while (!seen && k < e.n + 10) begin
            @(negedge lcdclk);
            k++;
            start = 1'b0;
            a_in  = WIDTH'($urandom);
            b_in  = WIDTH'($urandom);
            if (ghost && k == 2) begin
                start = 1'b1; a_in = 12'd5; b_in = 12'd10;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                if (ghost) begin
                    start = 1'b1; a_in = 12'd9; b_in = 12'd3;
                end
            end else begin
                chk("busy", busy, 1);
            end
        end
        chk("latency", k, e.n + 2);
        if (ghost) begin
            @(negedge lcdclk);
            start = 1'b0;
            chk("ghost_done", done, 0);
            chk("ghost_busy", busy, 0);
            chk("ghost_result", result, e.r);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge lcdclk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_iter", iter_cnt, 0);
        chk("rst_zerr", zero_err, 0);

        run_op(12, 18, 1'b0);
        run_op(4095, 1, 1'b0);
        run_op(0, 25, 1'b0);
        run_op(0, 0, 1'b0);
        run_op(25, 0, 1'b0);
        run_op(12, 18, 1'b1);
        run_op(21, 14, 1'b0);

        // Abort a long operation with reset in its cycle 2.
        @(negedge lcdclk);
        start = 1'b1; a_in = 12'd4095; b_in = 12'd1;
        @(negedge lcdclk);
        start = 1'b0;
        @(negedge lcdclk);
        reset = 1'b1;
        @(negedge lcdclk);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_iter", iter_cnt, 0);
        repeat (8) @(negedge lcdclk);
        chk("abort_idle", busy, 0);

        run_op(7, 7, 1'b0);
        run_op(4095, 4095, 1'b0);
        run_op(1, 4095, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op($urandom_range(0, 300), $urandom_range(0, 300), 1'b0);
        end
        run_op($urandom_range(1, 4095), $urandom_range(1, 4095), 1'b0);

        repeat (3) @(negedge lcdclk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
